// File: rtl/dual_port_fifo_ctrl.sv
// FIFO pointer/flag controller that sequences a synchronous dual-port RAM.
// Generates RAM strobes and addresses, occupancy, level flags and error pulses.
module dual_port_fifo_ctrl #(
  parameter int wi     = 8,
  parameter int dep    = 16,
  parameter int add    = 4,
  parameter int af_lvl = 12,
  parameter int ae_lvl = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  output logic           ram_wr,
  output logic           ram_rd,
  output logic [add-1:0] ram_wa,
  output logic [add-1:0] ram_ra,
  output logic           rd_valid,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic [add:0]   count,
  output logic           ovf,
  output logic           unf
);

  // wi only mirrors the RAM instance; folding it in keeps the parameter referenced.
  localparam logic [add:0] c_dep = (add+1)'(dep + 0 * wi);
  localparam logic [add:0] c_af  = (add+1)'(af_lvl);
  localparam logic [add:0] c_ae  = (add+1)'(ae_lvl);

  logic [add-1:0] r_wptr;
  logic [add-1:0] r_rptr;
  logic [add:0]   r_count;
  logic           r_rd_valid;
  logic           r_ovf;
  logic           r_unf;

  logic w_push_ok;
  logic w_pop_ok;

  // NOTE: accept terms are gated by rst so a reset cycle never strobes the RAM.
  assign w_push_ok = push & ~full  & rst;
  assign w_pop_ok  = pop  & ~empty & rst;

  assign ram_wr = w_push_ok;
  assign ram_rd = w_pop_ok;
  assign ram_wa = r_wptr;
  assign ram_ra = r_rptr;

  // Flags decode the registered count only, so they never glitch on requests.
  assign full         = (r_count == c_dep);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= c_af);
  assign almost_empty = (r_count <= c_ae);

  assign count    = r_count;
  assign rd_valid = r_rd_valid;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rd_valid <= w_pop_ok;
      r_ovf      <= push & full;
      r_unf      <= pop & empty;
    end
  end

endmodule

// File: doc/dual_port_fifo_ctrl.md
Name: dual_port_fifo_ctrl

Overview:
- Pointer and flag controller that sequences the synchronous dual-port RAM (dual_port_syn) as a first-in-first-out buffer.
- Takes push/pop requests from producer and consumer logic and drives the RAM's wr, rd, wa and ra.
- Maintains occupancy, generates full/empty/almost flags and error pulses, and marks the cycle in which RAM dout is valid.
- Write data goes straight from the producer to RAM din. This block carries no data.

Parameters:
- wi, 8, RAM data width; not used inside this block, kept for matching the RAM instance.
- dep, 16, RAM depth in words; must equal 2**add.
- add, 4, address width.
- af_lvl, 12, almost_full asserts when count >= af_lvl.
- ae_lvl, 4, almost_empty asserts when count <= ae_lvl.

Ports:
- clk  input  1  clock; everything samples on posedge.
- rst  input  1  synchronous active-low reset, sampled on posedge clk.
- push  input  1  producer write request; data is presented on RAM din in the same cycle.
- pop  input  1  consumer read request.
- ram_wr  output  1  to RAM wr.
- ram_rd  output  1  to RAM rd.
- ram_wa  output  add  to RAM wa (the write pointer).
- ram_ra  output  add  to RAM ra (the read pointer).
- rd_valid  output  1  RAM dout holds popped data this cycle.
- full  output  1  count == dep.
- empty  output  1  count == 0.
- almost_full  output  1  count >= af_lvl.
- almost_empty  output  1  count <= ae_lvl.
- count  output  add+1  current occupancy, range 0..dep.
- ovf  output  1  one-cycle pulse: a push was rejected.
- unf  output  1  one-cycle pulse: a pop was rejected.

Behaviour:
- Reset (rst==0 at posedge):
  - wptr, rptr and count go to 0; rd_valid, ovf and unf go to 0.
  - Outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0, ram_wa=0, ram_ra=0.
  - Reset overrides push and pop in the same cycle.
  - A reset that lands mid-operation drops any in-flight read: rd_valid=0 on the following cycle. RAM contents are not cleared.
- Accept terms (combinational):
  - push_ok = push & ~full; pop_ok = pop & ~empty.
  - ram_wr = push_ok; ram_rd = pop_ok; ram_wa = wptr; ram_ra = rptr.
- Pointers:
  - wptr increments on push_ok; rptr increments on pop_ok.
  - Both are add bits wide and wrap from dep-1 to 0 with no special case.
- Count update, registered:
  - push_ok only: +1.
  - pop_ok only: -1.
  - Both, or neither: unchanged.
- Flags: full, empty, almost_full and almost_empty are decoded from the registered count, so they are glitch-free and update the cycle after the event.
- Simultaneous push and pop:
  - Not full and not empty: both are accepted, count is unchanged, and the RAM writes and reads different addresses.
  - Full: the push is rejected (ovf=1 next cycle) and the pop is accepted. No same-address read/write ever occurs.
  - Empty: the pop is rejected (unf=1 next cycle) and the push is accepted. There is no write-to-read bypass.
- Read latency:
  - The RAM read is synchronous, so dout is valid one cycle after ram_rd.
  - rd_valid is ram_rd registered: 1 cycle after pop_ok, for exactly 1 cycle per accepted pop.
- Error pulses:
  - ovf(t+1) = push & full at t; unf(t+1) = pop & empty at t.
  - Pointers and count do not change on a rejected request.
- Ordering: data emerges in push order. The oldest entry is always at rptr.
- Constraints: 0 <= ae_lvl < af_lvl <= dep. These are not checked in RTL.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst=0 for 2 cycles with push=1 and pop=1, then release.
   - Response: count=0, empty=1, full=0, ram_wr=0, ram_rd=0, rd_valid=0 throughout reset; on release, empty=1 and wptr=rptr=0.
2. Fill to full:
   - Stimulus: 16 consecutive pushes of din=8'h10..8'h1F, then a 17th push.
   - Response:
     - ram_wa runs 0..15.
     - almost_full rises when count reaches 12; full=1 once count=16.
     - 17th push: ram_wr=0, ovf=1 for one cycle, count stays 16.
3. Drain and order:
   - Stimulus: from full, 16 consecutive pops, then one extra pop.
   - Response:
     - ram_ra runs 0..15; rd_valid lags each pop by 1 cycle.
     - dout reads 8'h10..8'h1F in order.
     - almost_empty=1 once count<=4; empty=1 at count=0.
     - Extra pop: unf=1, rd_valid=0.
4. Wrap-around:
   - Stimulus: push 10, pop 10, then push 10 values 8'hA0..8'hA9.
   - Response: ram_wa runs 10..15, 0..3; subsequent pops return 8'hA0..8'hA9 in order; count returns to 0.
5. Simultaneous push and pop:
   - At count=5, push+pop for 4 cycles: count stays 5 and data order is preserved.
   - At full, push+pop: pop accepted, push rejected, ovf=1, count=15.
   - At empty, push+pop: push accepted, unf=1, count=1, rd_valid=0.
6. Reset mid-operation:
   - Stimulus: count=7 with a pop accepted at t; assert rst at t+1.
   - Response: rd_valid=0 at t+2, count=0, empty=1, and pointers are 0.
